uart_rx_oversampled: RTL and testbench

- UART receiver stage directly upstream of the ALU command interface.
- Recovers 8N1-style serial frames from the `rx` pin using an internal 16x oversampling baud tick.
- Presents each received byte on `rx_data_out` with a one-cycle `rx_done_tick` strobe, which the interface consumes to load A, B and Op.
- Flags bad stop bits and suppresses delivery of those frames.

---
 rtl/uart_rx_oversampled.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
//
// UART receiver for 8N1-style frames, using an internal 16x oversampling tick.
// Each byte with a good stop bit is presented on rx_data_out together with a
// one-cycle rx_done_tick strobe. A stop bit sampled low produces a one-cycle
// frame_err pulse instead, leaves rx_data_out untouched, and parks the receiver
// until the line returns high. This keeps a held-low line (break) from being
// decoded as a stream of 0x00 bytes.
//
// Parameters
//   NBIT_DATA_LEN : data bits per frame, LSB first (>= 2)
//   SB_TICK       : oversampling ticks spent in the stop bit (16, 24 or 32)
//   BAUD_DIV      : clk cycles per oversampling tick (2..4095)
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   rx           : asynchronous serial input, idle high
//   rx_done_tick : one-cycle pulse, a valid byte is now on rx_data_out
//   rx_data_out  : last validly received byte, held between strobes
//   frame_err    : one-cycle pulse, the stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_oversampled #(
    parameter int NBIT_DATA_LEN = 8,
    parameter int SB_TICK       = 16,
    parameter int BAUD_DIV      = 326
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    output logic                     rx_done_tick,
    output logic [NBIT_DATA_LEN-1:0] rx_data_out,
    output logic                     frame_err
);

    localparam int S_W    = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W    = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;
    localparam int BAUD_W = 12;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);
    localparam logic [S_W-1:0]    S_MID       = S_W'(7);
    localparam logic [S_W-1:0]    S_BIT_LAST  = S_W'(15);
    localparam logic [S_W-1:0]    S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]    N_LAST      = N_W'(NBIT_DATA_LEN - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic                     rx_meta_q, rx_meta_d;
    logic                     rx_s_q, rx_s_d;
    logic [BAUD_W-1:0]        baud_cnt_q, baud_cnt_d;
    logic                     s_tick;
    logic [2:0]               state_q, state_d;
    logic [S_W-1:0]           s_q, s_d;
    logic [N_W-1:0]           n_q, n_d;
    logic [NBIT_DATA_LEN-1:0] b_q, b_d;
    logic [NBIT_DATA_LEN-1:0] data_q, data_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    // Two-flop synchronizer; the receiver only ever looks at rx_s_q.
    assign rx_meta_d = rx;
    assign rx_s_d    = rx_meta_q;

    // Free-running tick generator. It is deliberately not realigned to the
    // start edge, so the start-edge phase error is at most one tick (1/16 bit).
    assign s_tick     = (baud_cnt_q == BAUD_LAST);
    assign baud_cnt_d = s_tick ? '0 : baud_cnt_q + 1'b1;

    // NOTE: every signal gets a default at the top of this block, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Checked on every clk, so a start edge is seen without waiting
                // for the next tick.
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // If the line is high again at mid start bit, the edge
                        // was a glitch: drop it silently.
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        b_d = {rx_s_q, b_q[NBIT_DATA_LEN-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Line activity before the final sample is ignored; only that
                // one sample decides whether the frame is valid.
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        if (rx_s_q) begin
                            data_d  = b_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            baud_cnt_q <= '0;
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            baud_cnt_q <= baud_cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_done_tick = done_q;
    assign rx_data_out  = data_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
//
// Two receivers share clk/rst_n: dut16 (one stop bit) and dut32 (two stop
// bits), each on its own serial line. Stimulus tasks push the expected event
// for each frame (byte, or framing error if the stop bit is driven low) into a
// per-line queue. A monitor pops and compares whenever a receiver strobes.
// With BAUD_DIV=4 one bit lasts 64 clk.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CLK  = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rx32  = 1'b1;
    logic       done16, err16, done32, err32;
    logic [7:0] data16, data32;

    uart_rx_oversampled #(.NBIT_DATA_LEN(8), .SB_TICK(16), .BAUD_DIV(BAUD_DIV)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_done_tick(done16), .rx_data_out(data16), .frame_err(err16)
    );

    uart_rx_oversampled #(.NBIT_DATA_LEN(8), .SB_TICK(32), .BAUD_DIV(BAUD_DIV)) dut32 (
        .clk(clk), .rst_n(rst_n), .rx(rx32),
        .rx_done_tick(done32), .rx_data_out(data32), .frame_err(err32)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp16_q[$];
    ev_t        exp32_q[$];
    logic [7:0] last_good [2];
    int         done_cnt [2];
    int         err_cnt [2];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_window(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic observe(input int i, input logic done, input logic err, input logic [7:0] data);
        ev_t ev;
        int  depth;
        if (!done && !err) return;
        if (done) done_cnt[i]++;
        if (err)  err_cnt[i]++;
        depth = (i == 0) ? exp16_q.size() : exp32_q.size();
        check($sformatf("dut%0d_event_was_expected", i), depth > 0, 1'b1);
        if (depth == 0) return;
        if (i == 0) ev = exp16_q.pop_front();
        else        ev = exp32_q.pop_front();
        check($sformatf("dut%0d_done_err_exclusive", i), done & err, 1'b0);
        check($sformatf("dut%0d_event_kind_is_err", i), err, ev.is_err);
        if (ev.is_err) begin
            check($sformatf("dut%0d_data_held_on_err", i), data, last_good[i]);
        end else begin
            check($sformatf("dut%0d_data", i), data, ev.data);
            last_good[i] = ev.data;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, done16, err16, data16);
            observe(1, done32, err32, data32);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int line, input logic v);
        if (line == 0) rx = v;
        else           rx32 = v;
    endtask

    task automatic idle(input int line, input int n);
        drive(line, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge that ends the stop bit(s).
    task automatic send_frame(input int line, input logic [7:0] data, input int bit_clk,
                              input int stop_bits, input logic stop_val);
        ev_t ev;
        ev.is_err = ~stop_val;
        ev.data   = data;
        if (line == 0) exp16_q.push_back(ev);
        else           exp32_q.push_back(ev);
        drive(line, 1'b0);
        repeat (bit_clk) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive(line, data[k]);
            repeat (bit_clk) @(negedge clk);
        end
        drive(line, stop_val);
        repeat (bit_clk * stop_bits) @(negedge clk);
    endtask

    // Counts rising edges from the start-bit edge until rx_done_tick is seen.
    task automatic measure(input int line, input int lo, input int hi, input string name);
        int   cycles = 0;
        logic seen   = 1'b0;
        while (!seen && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            seen = (line == 0) ? done16 : done32;
        end
        check({name, "_strobe_seen"}, seen, 1'b1);
        if (seen) check_window({name, "_latency"}, cycles, lo, hi);
    endtask

    initial begin
        int d0, e0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        done_cnt = '{0, 0};
        err_cnt  = '{0, 0};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_done16", done16, 1'b0);
        check("rst_err16", err16, 1'b0);
        check("rst_data16", data16, 8'h00);
        check("rst_data32", data32, 8'h00);
        rst_n = 1'b1;
        idle(0, 20);

        // Reset hold mid-frame: load a byte first so the clear is visible
        send_frame(0, 8'hC3, BIT_CLK, 1, 1'b1);
        idle(0, 100);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b0;
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_done16", done16, 1'b0);
        check("midrst_err16", err16, 1'b0);
        check("midrst_data16", data16, 8'h00);
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        rst_n = 1'b1;
        idle(0, 300);
        check("postrst_no_strobe", done_cnt[0] - d0, 0);
        check("postrst_no_err", err_cnt[0] - e0, 0);
        check("postrst_data16", data16, 8'h00);
        fork
            send_frame(0, 8'hA5, BIT_CLK, 1, 1'b1);
            measure(0, 608, 611, "sb16");
        join
        idle(0, 50);

        // Back-to-back frames, no idle gap
        send_frame(0, 8'h03, BIT_CLK, 1, 1'b1);
        send_frame(0, 8'h05, BIT_CLK, 1, 1'b1);
        send_frame(0, 8'h20, BIT_CLK, 1, 1'b1);
        idle(0, 100);

        // Glitch rejection: 16 clk low is a quarter bit
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        rx = 1'b0;
        repeat (16) @(negedge clk);
        idle(0, 100);
        check("glitch_no_strobe", done_cnt[0] - d0, 0);
        check("glitch_no_err", err_cnt[0] - e0, 0);
        send_frame(0, 8'h3C, BIT_CLK, 1, 1'b1);
        idle(0, 100);

        // Framing error followed by a held-low line
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        send_frame(0, 8'h5A, BIT_CLK, 1, 1'b0);
        repeat (500) @(negedge clk);
        check("break_single_err", err_cnt[0] - e0, 1);
        check("break_no_strobe", done_cnt[0] - d0, 0);
        check("break_data_kept", data16, 8'h3C);
        idle(0, 100);
        send_frame(0, 8'h11, BIT_CLK, 1, 1'b1);
        idle(0, 100);

        // Baud tolerance +/-3%
        send_frame(0, 8'hFF, 66, 1, 1'b1);
        idle(0, 80);
        send_frame(0, 8'h00, 66, 1, 1'b1);
        idle(0, 80);
        send_frame(0, 8'hFF, 62, 1, 1'b1);
        idle(0, 80);
        send_frame(0, 8'h00, 62, 1, 1'b1);
        idle(0, 80);

        // Two stop bits on the SB_TICK=32 receiver
        fork
            send_frame(1, 8'h81, BIT_CLK, 2, 1'b1);
            measure(1, 672, 675, "sb32");
        join
        idle(1, 100);

        // Random bytes, random bit period within +/-3%, random gaps (incl. none)
        for (int f = 0; f < 16; f++) begin
            send_frame(0, 8'($urandom), $urandom_range(62, 66), 1, 1'b1);
            idle(0, $urandom_range(0, 80));
        end

        idle(0, 800);
        check("q16_drained", exp16_q.size(), 0);
        check("q32_drained", exp32_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
